// File: rtl/pe_mac_bank.sv
// pe_mac_bank: fixed-point MAC processing element with banked accumulators and a rounding/saturating drain
module pe_mac_bank #(
    parameter int INT_BITS       = 7,
    parameter int FRAC_BITS      = 9,
    parameter int NUM_ACC        = 8,
    parameter int GUARD_BITS     = 4,
    parameter bit CLEAR_ON_DRAIN = 1'b1,
    localparam int W     = INT_BITS + FRAC_BITS,
    localparam int IDX_W = $clog2(NUM_ACC),
    localparam int ACC_W = 2 * W + GUARD_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [IDX_W-1:0] in_sel,
    input  logic             in_first,
    input  logic             drain_req,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             sat_flag
);
    localparam int RW = ACC_W - FRAC_BITS + 1;
    localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (FRAC_BITS - 1);
    localparam logic signed [RW-1:0] R_MAX = RW'((1 << (W - 1)) - 1);
    localparam logic signed [RW-1:0] R_MIN = ~R_MAX;

    typedef enum logic [1:0] {IDLE, FLUSH, EMIT} state_t;
    state_t state_q, state_d;
    logic in_v_q, in_v_d, in_first_q, in_first_d, p_v_q, p_v_d, p_first_q, p_first_d;
    logic signed [W-1:0] a_q, a_d, b_q, b_d;
    logic [IDX_W-1:0] in_sel_q, in_sel_d, p_sel_q, p_sel_d;
    logic signed [2*W-1:0] prod_q, prod_d;
    logic signed [ACC_W-1:0] acc_q [NUM_ACC];
    logic signed [ACC_W-1:0] acc_d [NUM_ACC];
    logic out_valid_q, out_valid_d, out_last_q, out_last_d, sat_q, sat_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic in_fire, out_fire, load;
    logic [IDX_W-1:0] ld_idx;
    logic signed [RW-1:0] rnd;
    logic rnd_hi, rnd_lo;

    // Inputs are refused while draining or when a drain is being requested this cycle
    assign in_ready  = rst_n && state_q == IDLE && !drain_req;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign sat_flag  = sat_q;

    // Round half toward +inf the accumulator feeding the next output beat and detect clamping
    always_comb begin
        ld_idx = state_q == FLUSH ? '0 : out_idx_q + 1'b1;
        rnd    = RW'(({acc_q[ld_idx][ACC_W-1], acc_q[ld_idx]} + HALF) >> FRAC_BITS);
        rnd_hi = rnd > R_MAX;
        rnd_lo = rnd < R_MIN;
    end

    // Next state for operand register, product stage, accumulators, drain FSM and output register
    always_comb begin
        in_fire    = in_valid && in_ready;
        out_fire   = out_valid_q && out_ready;
        load       = (state_q == FLUSH && !in_v_q && !p_v_q) || (state_q == EMIT && out_fire && !out_last_q);
        in_v_d     = in_fire;
        a_d        = in_fire ? in_a : a_q;
        b_d        = in_fire ? in_b : b_q;
        in_sel_d   = in_fire ? in_sel : in_sel_q;
        in_first_d = in_fire ? in_first : in_first_q;
        p_v_d      = in_v_q;
        prod_d     = in_v_q ? (2 * W)'(a_q) * (2 * W)'(b_q) : prod_q;
        p_sel_d    = in_v_q ? in_sel_q : p_sel_q;
        p_first_d  = in_v_q ? in_first_q : p_first_q;
        acc_d      = acc_q;
        if (p_v_q)
            acc_d[p_sel_q] = p_first_q ? ACC_W'(prod_q) : acc_q[p_sel_q] + ACC_W'(prod_q);
        if (CLEAR_ON_DRAIN && out_fire)
            acc_d[out_idx_q] = '0;
        state_d     = state_q == IDLE  ? (drain_req ? FLUSH : IDLE)
                    : state_q == FLUSH ? (load ? EMIT : FLUSH)
                    : (out_fire && out_last_q ? IDLE : EMIT);
        out_valid_d = load || (out_valid_q && !out_fire);
        out_data_d  = !load ? out_data_q
                    : rnd_hi ? {1'b0, {(W - 1){1'b1}}}
                    : rnd_lo ? {1'b1, {(W - 1){1'b0}}}
                    : rnd[W-1:0];
        out_idx_d   = load ? ld_idx : out_idx_q;
        out_last_d  = load ? ld_idx == IDX_W'(NUM_ACC - 1) : out_last_q && !out_fire;
        sat_d       = state_q == IDLE && drain_req ? 1'b0 : sat_q || (load && (rnd_hi || rnd_lo));
    end

    // Register all state; reset clears everything and aborts any drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_v_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            in_sel_q    <= '0;
            in_first_q  <= 1'b0;
            p_v_q       <= 1'b0;
            prod_q      <= '0;
            p_sel_q     <= '0;
            p_first_q   <= 1'b0;
            for (int i = 0; i < NUM_ACC; i++)
                acc_q[i] <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_v_q      <= in_v_d;
            a_q         <= a_d;
            b_q         <= b_d;
            in_sel_q    <= in_sel_d;
            in_first_q  <= in_first_d;
            p_v_q       <= p_v_d;
            prod_q      <= prod_d;
            p_sel_q     <= p_sel_d;
            p_first_q   <= p_first_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
        end
    end
endmodule

// File: doc/pe_mac_bank.md
Name: pe_mac_bank

Overview:
Parametrised fixed-point multiply-accumulate processing element. It is the next-generation PE for the systolic/MAC datapath. Signed Qm.n operands are multiplied and accumulated into one of NUM_ACC selectable wide accumulators with guard bits. On request, a drain FSM streams every accumulator out in index order, rounded and saturated back to operand format, over a valid/ready handshake. Each drain can optionally clear the accumulators.

Parameters:
INT_BITS, 7, integer bits of operand/result incl. sign (W = INT_BITS+FRAC_BITS)
FRAC_BITS, 9, fractional bits of operand/result
NUM_ACC, 8, number of accumulators (>=2); IDX_W = clog2(NUM_ACC)
GUARD_BITS, 4, extra accumulator MSBs; ACC_W = 2*W+GUARD_BITS
CLEAR_ON_DRAIN, 1, 1 = each accumulator zeroed as its output beat is accepted

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous assert, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  PE can accept operand beat
in_a  in  W  signed operand A, Q(INT_BITS).(FRAC_BITS)
in_b  in  W  signed operand B
in_sel  in  IDX_W  target accumulator
in_first  in  1  beat overwrites accumulator (acc = product) instead of adding
drain_req  in  1  pulse/level: start drain of all accumulators
busy  out  1  drain in progress (incl. pipeline flush)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  W  rounded, saturated result
out_idx  out  IDX_W  accumulator index of out_data
out_last  out  1  high on beat for index NUM_ACC-1
sat_flag  out  1  sticky: some output beat saturated since last drain start

Behaviour:
- Reset (rst_n low, async): all accumulators 0, pipeline valids 0, FSM IDLE, in_ready 0 during reset then 1, out_valid 0, out_data 0, out_idx 0, out_last 0, busy 0, sat_flag 0. Reset mid-drain aborts the drain; no further beats are emitted.
- Input accept: in_valid & in_ready. in_ready = (state==IDLE) & !drain_req.
- Stage 1 (edge after accept): the registered full-precision product, 2W bits signed, with 2*FRAC_BITS fractional bits. The stage also registers sel and first.
- Stage 2 (next edge): acc[sel] <= first ? sext(prod) : acc[sel] + sext(prod).
  - ACC_W wraps on overflow; no internal saturation.
  - Back-to-back beats to the same index need no stall, because the read-modify-write completes in one cycle.
- Accumulate latency: beat accepted at edge t, so acc visible at edge t+2.
- Drain FSM states IDLE -> FLUSH -> EMIT -> IDLE.
  - IDLE: drain_req=1 -> FLUSH. Also clears sat_flag and sets busy.
  - FLUSH: wait until both pipeline stages are empty (at most 2 cycles), then EMIT with idx=0.
  - EMIT: out register loaded from round(acc[idx]); out_valid=1.
    - Hold out_data/out_idx/out_last stable while out_valid & !out_ready.
    - On accept: if CLEAR_ON_DRAIN, acc[idx] <= 0.
    - If idx==NUM_ACC-1, go to IDLE with out_valid 0 next cycle and busy 0. Otherwise idx+1 and load the next beat in the same edge, giving 1 beat/cycle sustained throughput when out_ready=1.
  - drain_req ignored outside IDLE.
- Rounding: add 2^(FRAC_BITS-1) to acc (round half toward +inf), arithmetic shift right FRAC_BITS.
- Saturation: if the result exceeds the signed W range, clamp to 0x7FFF-style max / 0x8000-style min and set sat_flag.
- Simultaneous in_valid and drain_req in IDLE: drain wins; in_ready=0 that cycle, so the beat is not accepted.

Test Plan:
- Reset mid-drain: assert rst_n low during EMIT -> all outputs return to reset values immediately; post-reset drain yields all zeros.
- Q7.9 basics: a=0x0300 (1.5), b=0x0400 (2.0), sel=2, first=1. Then a=0xFE00 (-1.0), b=0x0100 (0.5), sel=2, first=0. Then drain -> idx2 out_data=0x0500 (2.5), all other idx 0x0000, out_last on idx7, sat_flag=0.
- Rounding: a=0x0001, b=0x0100 into acc0 -> 0x0001. a=0xFFFF, b=0x0100 into acc1 -> 0x0000 (half rounds up). a=0x0001, b=0x00FF into acc2 -> 0x0000.
- Saturation: 4× (0x7E00*0x7E00, 63*63) into acc3 -> out 0x7FFF and sat_flag=1. Same with a=0x8200 into acc4 -> 0x8000.
- Backpressure: out_ready low for 5 cycles at idx 3 -> out_data/idx stable, no skipped or duplicated index. With CLEAR_ON_DRAIN=1, a second drain returns all 0x0000.
- Hazards: beats to sel=5 on 4 consecutive cycles with drain_req asserted the cycle after the last -> in_ready drops, FLUSH lasts 2 cycles, idx5 includes all 4 products. Concurrent in_valid+drain_req -> beat rejected.
